riscv_htif_mem_arbiter: RTL and testbench
=========================================

// Module: riscv_htif_mem_arbiter
// PURPOSE
//  Shares the single CPU memory request port (htif_req_*/htif_resp_*) between NREQ requesters
//  (port 0 = riscvHTIF, others = debug/DMA masters). Round-robin grant, one registered request
//  stage, per-requester outstanding-response tracking; responses routed back by tag.
// PARAMETERS
//  NREQ      2   number of requesters (2..8)
//  TAG_W     12  downstream tag width (matches htif_req_tag)
//  MAX_OUTST 4   max outstanding responses per requester (power of 2)
// PORTS
//  clk          in   1             clock; one clock, all logic on posedge clk
//  rst_n        in   1             reset is asynchronous and active-low
//  rq_val       in   NREQ          requester i request valid
//  rq_rdy       out  NREQ          requester i request accepted this cycle
//  rq_op        in   NREQ x 4      M_XRD / M_XWR / M_FLA
//  rq_addr      in   NREQ x 32     address
//  rq_data      in   NREQ x 64     write data
//  rq_wmask     in   NREQ x 8      byte mask
//  rq_tag       in   NREQ x TAG_W-ID_W requester-local tag, ID_W=$clog2(NREQ)
//  rs_val       out  NREQ          response valid to requester i
//  rs_data      out  64            response data (shared bus)
//  rs_tag       out  TAG_W-ID_W    requester-local tag of response
//  mem_req_val  out  1             downstream request valid
//  mem_req_rdy  in   1             downstream ready
//  mem_req_op/addr/data/wmask/tag out 4/32/64/8/TAG_W  downstream fields
//  mem_resp_val in   1             downstream response valid
//  mem_resp_data in  64            downstream response data
//  mem_resp_tag in   TAG_W         downstream response tag
//  error        out  1             sticky protocol error
// BEHAVIOUR
//  FSM ARB_IDLE / ARB_SEND. Reset: ARB_IDLE, rr pointer=0, counters=0, all outputs 0.
//  ARB_IDLE: eligible[i] = rq_val[i] && outst[i] < MAX_OUTST. Winner = first eligible at or
//   after rr pointer (wrapping). rq_rdy[winner]=1 same cycle (only rq_rdy in ARB_SEND = 0);
//   fields captured, tag = {winner, rq_tag}; outst[winner]++; rr pointer = winner+1 mod NREQ;
//   -> ARB_SEND. No eligible -> stay.
//  ARB_SEND: mem_req_val=1, fields from capture regs, stable until mem_req_rdy; on rdy -> ARB_IDLE.
//   Request reaches mem port 1 cycle after accept; peak throughput 1 request / 2 cycles.
//  Response path combinational: id = mem_resp_tag[TAG_W-1 -: ID_W]; rs_val[id]=mem_resp_val,
//   rs_data/rs_tag passthrough; outst[id]--. Every request (incl. M_FLA) gets exactly one response.
//  Same-cycle accept and response for same id: counter unchanged.
//  Response with id >= NREQ or outst[id]==0: dropped (no rs_val), error set, sticky until reset.
//  Counter at MAX_OUTST: requester ineligible; no overflow possible.
//  rst_n low mid-SEND: captured request discarded, mem_req_val drops asynchronously.
// CONFIGURATION
//  HTIF_ARB_LOCK_EN defined: extra input rq_lock[NREQ]. Accepting a request with rq_lock[i]=1
//   sets lock_owner=i; while locked only requester i is eligible; accepting i with rq_lock=0
//   releases (that request still granted). rr pointer not advanced while locked.
//  Undefined: no rq_lock port, pure round-robin.
// STRUCTURE
//  Package riscv_htif_arb_pkg: arb_state_t enum, M_XRD/M_XWR/M_FLA op constants re-export,
//   function id_w(NREQ), tag compose/split helpers.
//  Sub-module riscv_rr_picker: NREQ-wide round-robin one-hot picker (req, ptr -> grant, valid).
// TESTING
//  Both rq_val=1 every cycle, rdy=1, immediate resp -> grants alternate 0,1,0,1; 1 req/2 cycles.
//  rq_val[1] only, tag 0x05, mem_req_rdy low 3 cycles -> mem_req_val held, mem_req_tag=0x805.
//  Requester 0 issues 4 reads, no responses -> 5th not accepted; one response -> accepted next.
//  mem_resp_val with tag 0x800 while outst[1]==0 -> rs_val=0, error=1 and stays 1.
//  rst_n low during ARB_SEND -> mem_req_val=0 immediately, counters 0, error 0 after release.
//  HTIF_ARB_LOCK_EN: req 1 with lock, both rq_val -> req 1 granted until unlocked request.

Source files
------------

// File: rtl/riscv_htif_arb_pkg.sv
// Shared types and helpers for the HTIF memory-port arbiter.
// Optional feature macro used by the arbiter: HTIF_ARB_LOCK_EN.
package riscv_htif_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_SEND = 1'b1
  } arb_state_t;

  // Memory opcodes carried on the request port (passed through untouched).
  localparam logic [3:0] M_XRD = 4'b0000;
  localparam logic [3:0] M_XWR = 4'b0001;
  localparam logic [3:0] M_FLA = 4'b0110;

  // Width of the requester id field; never narrower than one bit.
  function automatic int id_w(input int nreq);
    return (nreq <= 32'sd1) ? 32'sd1 : $clog2(nreq);
  endfunction

  // Build a downstream tag: requester id above the requester-local tag.
  function automatic logic [31:0] tag_compose(input logic [31:0] id, input logic [31:0] ltag,
                                              input int ltag_w);
    return (id << ltag_w) | ltag;
  endfunction

  // Recover the requester id from a downstream tag.
  function automatic logic [31:0] tag_id(input logic [31:0] tag, input int ltag_w);
    return tag >> ltag_w;
  endfunction

endpackage

// File: rtl/riscv_rr_picker.sv
// Round-robin one-hot picker: first asserted request at or after ptr, wrapping.
module riscv_rr_picker
  import riscv_htif_arb_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int ID_W = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic            valid
);

  logic [ID_W:0]   sum_s;
  logic [ID_W-1:0] idx_s;

  // Walk the requesters starting at ptr; only the first request seen wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    sum_s = '0;
    idx_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum_s = {1'b0, ptr} + (ID_W+1)'(k);
      sum_s = (sum_s >= (ID_W+1)'(NREQ)) ? (sum_s - (ID_W+1)'(NREQ)) : sum_s;
      idx_s = sum_s[ID_W-1:0];
      grant[idx_s] = req[idx_s] & ~valid;
      valid = valid | req[idx_s];
    end
  end

endmodule

// File: rtl/riscv_htif_mem_arbiter.sv
// Shares one CPU memory request port among NREQ requesters with round-robin
// grant, a single registered request stage and per-requester outstanding
// response counters. Responses are steered back by the id in the tag MSBs.
// Optional macro HTIF_ARB_LOCK_EN adds rq_lock for locked request sequences.
module riscv_htif_mem_arbiter
  import riscv_htif_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int TAG_W     = 12,
  parameter int MAX_OUTST = 4,
  localparam int ID_W   = id_w(NREQ),
  localparam int LTAG_W = TAG_W - ID_W,
  localparam int CNT_W  = $clog2(MAX_OUTST + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              rq_val,
  output logic [NREQ-1:0]              rq_rdy,
  input  logic [NREQ-1:0][3:0]         rq_op,
  input  logic [NREQ-1:0][31:0]        rq_addr,
  input  logic [NREQ-1:0][63:0]        rq_data,
  input  logic [NREQ-1:0][7:0]         rq_wmask,
  input  logic [NREQ-1:0][LTAG_W-1:0]  rq_tag,
`ifdef HTIF_ARB_LOCK_EN
  input  logic [NREQ-1:0]              rq_lock,
`endif
  output logic [NREQ-1:0]              rs_val,
  output logic [63:0]                  rs_data,
  output logic [LTAG_W-1:0]            rs_tag,
  output logic                         mem_req_val,
  input  logic                         mem_req_rdy,
  output logic [3:0]                   mem_req_op,
  output logic [31:0]                  mem_req_addr,
  output logic [63:0]                  mem_req_data,
  output logic [7:0]                   mem_req_wmask,
  output logic [TAG_W-1:0]             mem_req_tag,
  input  logic                         mem_resp_val,
  input  logic [63:0]                  mem_resp_data,
  input  logic [TAG_W-1:0]             mem_resp_tag,
  output logic                         error
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTST);

  arb_state_t                   state_r;
  arb_state_t                   state_nxt_s;
  logic [ID_W-1:0]              ptr_r;
  logic [NREQ-1:0][CNT_W-1:0]   outst_r;
  logic [3:0]                   cap_op_r;
  logic [31:0]                  cap_addr_r;
  logic [63:0]                  cap_data_r;
  logic [7:0]                   cap_wmask_r;
  logic [TAG_W-1:0]             cap_tag_r;
  logic                         error_r;

  logic [NREQ-1:0]              room_s;
  logic [NREQ-1:0]              lock_mask_s;
  logic [NREQ-1:0]              elig_s;
  logic [NREQ-1:0]              grant_s;
  logic                         pick_valid_s;
  logic [ID_W-1:0]              win_idx_s;
  logic                         accept_s;
  logic                         adv_en_s;
  logic [ID_W-1:0]              ptr_adv_s;
  logic [31:0]                  resp_id_full_s;
  logic [ID_W-1:0]              resp_id_s;
  logic                         resp_in_range_s;
  logic                         resp_ok_s;
  logic                         resp_bad_s;

`ifdef HTIF_ARB_LOCK_EN
  logic                         lock_act_r;
  logic [ID_W-1:0]              lock_owner_r;
`endif

  // Eligibility: valid request, room for another response, and lock owner if locked.
  always_comb begin
    room_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      room_s[i] = (outst_r[i] < MAX_C);
    end
`ifdef HTIF_ARB_LOCK_EN
    lock_mask_s = lock_act_r ? (NREQ'(1'b1) << lock_owner_r) : '1;
    adv_en_s    = ~rq_lock[win_idx_s];
`else
    lock_mask_s = '1;
    adv_en_s    = 1'b1;
`endif
    elig_s = rq_val & room_s & lock_mask_s;
  end

  riscv_rr_picker #(.NREQ(NREQ)) u_picker (
    .req   (elig_s),
    .ptr   (ptr_r),
    .grant (grant_s),
    .valid (pick_valid_s)
  );

  // Encode the one-hot grant and derive the handshake and next pointer.
  always_comb begin
    win_idx_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_idx_s = win_idx_s | (grant_s[i] ? ID_W'(i) : '0);
    end
    accept_s  = (state_r == ARB_IDLE) && pick_valid_s;
    ptr_adv_s = (win_idx_s == ID_W'(NREQ - 1)) ? '0 : (win_idx_s + ID_W'(1'b1));
  end

  // Decode the response id; responses for unknown or idle requesters are dropped.
  always_comb begin
    resp_id_full_s  = tag_id(32'(mem_resp_tag), LTAG_W);
    resp_id_s       = resp_id_full_s[ID_W-1:0];
    resp_in_range_s = (resp_id_full_s < 32'(NREQ));
    resp_ok_s       = mem_resp_val && resp_in_range_s && (outst_r[resp_id_s] != '0);
    resp_bad_s      = mem_resp_val && !resp_ok_s;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: accept moves to SEND, downstream ready returns to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ARB_IDLE: state_nxt_s = accept_s ? ARB_SEND : ARB_IDLE;
      ARB_SEND: state_nxt_s = mem_req_rdy ? ARB_IDLE : ARB_SEND;
      default:  state_nxt_s = ARB_IDLE;
    endcase
  end

  // FSM outputs plus the combinational response passthrough.
  always_comb begin
    rq_rdy        = accept_s ? grant_s : '0;
    mem_req_val   = (state_r == ARB_SEND);
    mem_req_op    = cap_op_r;
    mem_req_addr  = cap_addr_r;
    mem_req_data  = cap_data_r;
    mem_req_wmask = cap_wmask_r;
    mem_req_tag   = cap_tag_r;
    rs_val        = resp_ok_s ? (NREQ'(1'b1) << resp_id_s) : '0;
    rs_data       = mem_resp_data;
    rs_tag        = mem_resp_tag[LTAG_W-1:0];
    error         = error_r;
  end

  // Request capture stage: holds the winner's fields while waiting for mem_req_rdy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_op_r    <= '0;
      cap_addr_r  <= '0;
      cap_data_r  <= '0;
      cap_wmask_r <= '0;
      cap_tag_r   <= '0;
    end else if (accept_s) begin
      cap_op_r    <= rq_op[win_idx_s];
      cap_addr_r  <= rq_addr[win_idx_s];
      cap_data_r  <= rq_data[win_idx_s];
      cap_wmask_r <= rq_wmask[win_idx_s];
      cap_tag_r   <= {win_idx_s, rq_tag[win_idx_s]};
    end else begin
      cap_op_r    <= cap_op_r;
      cap_addr_r  <= cap_addr_r;
      cap_data_r  <= cap_data_r;
      cap_wmask_r <= cap_wmask_r;
      cap_tag_r   <= cap_tag_r;
    end
  end

  // Outstanding counters: +1 on accept, -1 on routed response, both cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst_r <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        case ({rq_rdy[i], rs_val[i]})
          2'b10:   outst_r[i] <= outst_r[i] + CNT_W'(1'b1);
          2'b01:   outst_r[i] <= outst_r[i] - CNT_W'(1'b1);
          default: outst_r[i] <= outst_r[i];
        endcase
      end
    end
  end

  // Round-robin pointer moves past each winner unless a lock is being taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (accept_s && adv_en_s) begin
      ptr_r <= ptr_adv_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

`ifdef HTIF_ARB_LOCK_EN
  // Lock tracking: each accept re-evaluates the lock from its rq_lock bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_act_r   <= 1'b0;
      lock_owner_r <= '0;
    end else if (accept_s) begin
      lock_act_r   <= rq_lock[win_idx_s];
      lock_owner_r <= win_idx_s;
    end else begin
      lock_act_r   <= lock_act_r;
      lock_owner_r <= lock_owner_r;
    end
  end
`endif

  // Sticky protocol error on any dropped response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_r <= 1'b0;
    end else if (resp_bad_s) begin
      error_r <= 1'b1;
    end else begin
      error_r <= error_r;
    end
  end

endmodule

// File: tb/tb_riscv_htif_mem_arbiter.sv
// Scoreboard bench for riscv_htif_mem_arbiter: a transaction-level model
// predicts grants, downstream requests and routed responses; a monitor
// process compares DUT outputs against the queued expectations.
module tb_riscv_htif_mem_arbiter;
  import riscv_htif_arb_pkg::*;

  localparam int NREQ    = 2;
  localparam int TAG_W   = 12;
  localparam int LTAG_W  = 11;
  localparam int TAGSPAN = 2048;
  localparam int MAXO    = 4;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic [NREQ-1:0]             rq_val;
  logic [NREQ-1:0]             rq_rdy;
  logic [NREQ-1:0][3:0]        rq_op;
  logic [NREQ-1:0][31:0]       rq_addr;
  logic [NREQ-1:0][63:0]       rq_data;
  logic [NREQ-1:0][7:0]        rq_wmask;
  logic [NREQ-1:0][LTAG_W-1:0] rq_tag;
  logic [NREQ-1:0]             rq_lock;
  logic [NREQ-1:0]             rs_val;
  logic [63:0]                 rs_data;
  logic [LTAG_W-1:0]           rs_tag;
  logic                        mem_req_val;
  logic                        mem_req_rdy;
  logic [3:0]                  mem_req_op;
  logic [31:0]                 mem_req_addr;
  logic [63:0]                 mem_req_data;
  logic [7:0]                  mem_req_wmask;
  logic [TAG_W-1:0]            mem_req_tag;
  logic                        mem_resp_val;
  logic [63:0]                 mem_resp_data;
  logic [TAG_W-1:0]            mem_resp_tag;
  logic                        error;

  riscv_htif_mem_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W), .MAX_OUTST(MAXO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rq_val(rq_val), .rq_rdy(rq_rdy), .rq_op(rq_op), .rq_addr(rq_addr),
    .rq_data(rq_data), .rq_wmask(rq_wmask), .rq_tag(rq_tag),
`ifdef HTIF_ARB_LOCK_EN
    .rq_lock(rq_lock),
`endif
    .rs_val(rs_val), .rs_data(rs_data), .rs_tag(rs_tag),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_op(mem_req_op),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_wmask(mem_req_wmask), .mem_req_tag(mem_req_tag),
    .mem_resp_val(mem_resp_val), .mem_resp_data(mem_resp_data),
    .mem_resp_tag(mem_resp_tag), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       op;
    logic [31:0]      addr;
    logic [63:0]      data;
    logic [7:0]       wmask;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct {
    logic [NREQ-1:0]   val;
    logic [63:0]       data;
    logic [LTAG_W-1:0] tag;
  } rsp_t;

  req_t             exp_req_q[$];
  rsp_t             exp_rsp_q[$];
  logic [TAG_W-1:0] pool_q[$];     // requests the memory has taken but not answered

  int   vectors     = 0;
  int   miscompares = 0;
  int   acc_cnt     = 0;

  // Reference model state
  int   m_out[NREQ];
  int   m_ptr;
  bit   m_busy;
  bit   m_err;
  bit   m_locked;
  int   m_owner;
  req_t m_cur;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit lock_ok(input int idx);
`ifdef HTIF_ARB_LOCK_EN
    return !m_locked || (idx == m_owner);
`else
    return (idx >= 0);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) m_out[i] = 0;
    m_ptr = 0; m_busy = 1'b0; m_err = 1'b0; m_locked = 1'b0; m_owner = 0;
    exp_req_q.delete(); exp_rsp_q.delete(); pool_q.delete();
  endtask

  // One clock cycle: inputs were driven at the negedge; predict and check, then advance.
  task automatic step();
    int w;
    int idx;
    int rid;
    bit rok;
    bit old_busy;
    logic [NREQ-1:0] exp_rdy;
    rsp_t rs;
    #1;
    old_busy = m_busy;
    w = -1;
    if (!old_busy) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (w < 0 && rq_val[idx] && m_out[idx] < MAXO && lock_ok(idx)) w = idx;
      end
    end
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    if (rq_rdy != '0) acc_cnt++;
    chk("rq_rdy", 64'(rq_rdy), 64'(exp_rdy));
    chk("mem_req_val", 64'(mem_req_val), 64'(old_busy));
    chk("error", 64'(error), 64'(m_err));
    rok = 1'b0;
    rid = 0;
    if (mem_resp_val) begin
      rid = int'(mem_resp_tag) / TAGSPAN;
      if (rid < NREQ && m_out[rid] > 0) begin
        rok = 1'b1;
        rs.val = '0;
        rs.val[rid] = 1'b1;
        rs.data = mem_resp_data;
        rs.tag = LTAG_W'(int'(mem_resp_tag) % TAGSPAN);
        exp_rsp_q.push_back(rs);
      end else begin
        m_err = 1'b1;
      end
    end
    if (old_busy && mem_req_rdy) begin
      pool_q.push_back(m_cur.tag);
      m_busy = 1'b0;
    end
    if (w >= 0) begin
      m_cur.op    = rq_op[w];
      m_cur.addr  = rq_addr[w];
      m_cur.data  = rq_data[w];
      m_cur.wmask = rq_wmask[w];
      m_cur.tag   = TAG_W'(w * TAGSPAN + int'(rq_tag[w]));
      exp_req_q.push_back(m_cur);
      m_busy = 1'b1;
      m_out[w]++;
`ifdef HTIF_ARB_LOCK_EN
      if (rq_lock[w]) begin
        m_locked = 1'b1;
        m_owner  = w;
      end else begin
        m_locked = 1'b0;
        m_ptr    = (w + 1) % NREQ;
      end
`else
      m_ptr = (w + 1) % NREQ;
`endif
    end
    if (rok) m_out[rid]--;
    @(negedge clk);
  endtask

  task automatic rand_fields();
    for (int i = 0; i < NREQ; i++) begin
      case ($urandom_range(2))
        0:       rq_op[i] = M_XRD;
        1:       rq_op[i] = M_XWR;
        default: rq_op[i] = M_FLA;
      endcase
      rq_addr[i]  = $urandom();
      rq_data[i]  = {$urandom(), $urandom()};
      rq_wmask[i] = 8'($urandom());
      rq_tag[i]   = LTAG_W'($urandom());
    end
  endtask

  // Memory side: answer one pending request with probability p (oldest or random order).
  task automatic rand_resp(input int p, input bit oldest);
    int idx;
    mem_resp_data = {$urandom(), $urandom()};
    if (pool_q.size() != 0 && $urandom_range(99) < p) begin
      idx = oldest ? 0 : $urandom_range(pool_q.size() - 1);
      mem_resp_tag = pool_q[idx];
      pool_q.delete(idx);
      mem_resp_val = 1'b1;
    end else begin
      mem_resp_tag = TAG_W'($urandom());
      mem_resp_val = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    rq_val = '0;
    mem_req_rdy = 1'b1;
    while ((pool_q.size() != 0 || m_busy) && n < 200) begin
      rand_resp(100, 1'b0);
      step();
      n++;
    end
    mem_resp_val = 1'b0;
    chk("drain_done", 64'(pool_q.size()), 64'd0);
  endtask

  // Monitor: compare every downstream handshake and every routed response.
  initial begin
    req_t r;
    rsp_t s;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (mem_req_val && mem_req_rdy) begin
          if (exp_req_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL mem_req_unexpected: got tag 0x%0h expected none at %0t", mem_req_tag, $time);
          end else begin
            r = exp_req_q.pop_front();
            chk("mem_req_op", 64'(mem_req_op), 64'(r.op));
            chk("mem_req_addr", 64'(mem_req_addr), 64'(r.addr));
            chk("mem_req_data", mem_req_data, r.data);
            chk("mem_req_wmask", 64'(mem_req_wmask), 64'(r.wmask));
            chk("mem_req_tag", 64'(mem_req_tag), 64'(r.tag));
          end
        end
        if (rs_val != '0) begin
          if (exp_rsp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL rs_unexpected: got rs_val 0x%0h expected 0x0 at %0t", rs_val, $time);
          end else begin
            s = exp_rsp_q.pop_front();
            chk("rs_val", 64'(rs_val), 64'(s.val));
            chk("rs_data", rs_data, s.data);
            chk("rs_tag", 64'(rs_tag), 64'(s.tag));
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    rq_val = '0; rq_lock = '0; mem_req_rdy = 1'b0;
    mem_resp_val = 1'b0; mem_resp_tag = '0; mem_resp_data = '0;
    rand_fields();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_mem_req_val", 64'(mem_req_val), 64'd0);
    chk("reset_rq_rdy", 64'(rq_rdy), 64'd0);
    chk("reset_rs_val", 64'(rs_val), 64'd0);
    chk("reset_error", 64'(error), 64'd0);
    chk("reset_mem_req_tag", 64'(mem_req_tag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Both requesters always valid, memory always ready and answering at once.
    acc_cnt = 0;
    repeat (40) begin
      rand_fields();
      rq_val = 2'b11;
      mem_req_rdy = 1'b1;
      rand_resp(100, 1'b1);
      step();
    end
    chk("throughput_accepts", 64'(acc_cnt), 64'd20);
    drain();

    // Requester 1 alone with local tag 5; memory stalls three cycles.
    rand_fields();
    rq_tag[1] = 11'h005;
    rq_val = 2'b10;
    mem_req_rdy = 1'b0;
    step();
    rq_val = 2'b00;
    repeat (3) begin
      step();
      chk("held_tag", 64'(mem_req_tag), 64'h805);
    end
    mem_req_rdy = 1'b1;
    step();
    drain();

    // Requester 0 saturates its outstanding budget, then one response frees a slot.
    acc_cnt = 0;
    rq_val = 2'b01;
    mem_req_rdy = 1'b1;
    mem_resp_val = 1'b0;
    repeat (12) begin
      rand_fields();
      step();
    end
    chk("outst_limit_accepts", 64'(acc_cnt), 64'd4);
    rand_resp(100, 1'b1);
    step();
    mem_resp_val = 1'b0;
    step();
    chk("slot_freed_accepts", 64'(acc_cnt), 64'd5);
    drain();

    // Response for requester 1 with nothing outstanding: dropped, error sticks.
    mem_resp_val = 1'b1;
    mem_resp_tag = 12'h800;
    mem_resp_data = {$urandom(), $urandom()};
    step();
    mem_resp_val = 1'b0;
    repeat (3) step();

    // Reset while a request waits at the memory port.
    rq_val = 2'b01;
    mem_req_rdy = 1'b0;
    step();
    rq_val = 2'b00;
    rst_n = 1'b0;
    #1;
    chk("rst_mem_req_val", 64'(mem_req_val), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_rq_rdy", 64'(rq_rdy), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    acc_cnt = 0;
    rq_val = 2'b01;
    mem_req_rdy = 1'b1;
    repeat (10) begin
      rand_fields();
      step();
    end
    chk("post_reset_accepts", 64'(acc_cnt), 64'd4);
    drain();

`ifdef HTIF_ARB_LOCK_EN
    // Requester 1 locks the port; requester 0 waits until an unlocked request.
    rq_val = 2'b11;
    rq_lock = 2'b10;
    repeat (8) begin
      rand_fields();
      rand_resp(100, 1'b1);
      step();
    end
    rq_lock = 2'b00;
    repeat (8) begin
      rand_fields();
      rand_resp(100, 1'b1);
      step();
    end
    drain();
`endif

    // Randomized traffic.
    repeat (400) begin
      rand_fields();
      for (int i = 0; i < NREQ; i++) rq_val[i] = ($urandom_range(99) < 60);
      mem_req_rdy = ($urandom_range(99) < 70);
      rand_resp(50, 1'b0);
      step();
    end
    drain();
    step();

    chk("exp_req_left", 64'(exp_req_q.size()), 64'd0);
    chk("exp_rsp_left", 64'(exp_rsp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
